// File: rtl/mips32_rf_pkg.sv
// rtl/mips32_rf_pkg.sv - shared types, defaults and packed-port helper for the register file
package mips32_rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Low bit index of port k inside a packed bus of w-bit ports.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset clear sequencer: walks every index once, then signals ready
module regfile_clear_seq
    import mips32_rf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          o_ready,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The edge that clears the last index also moves to RUN, so ready
    // rises DEPTH edges after reset is released.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        o_clr_we  = 1'b0;
        o_ready   = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                o_clr_we = !reset;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = RF_RUN;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            RF_RUN: begin
                o_ready = !reset;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    assign o_clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear sequencer and pending-write scoreboard
// Optional write-through bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import mips32_rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH),
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [NRD*AW-1:0]     i_raddr,
    output logic [NRD*DATA_W-1:0] o_rdata,
    input  logic                  i_issue,
    input  logic [AW-1:0]         i_issue_addr,
    output logic [NRD-1:0]        o_busy,
    output logic                  o_ready
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              run;
    logic              clr_we;
    logic [AW-1:0]     clr_addr;
    logic              wr_en;
    logic              iss_en;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .o_ready    (run),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    assign o_ready = run;
    assign wr_en   = run && i_we && (i_waddr != '0);
    assign iss_en  = run && i_issue && (i_issue_addr != '0);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Issue is applied after the write so a same-cycle issue to the
    // written register keeps it busy: the newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[i_waddr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[i_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_live;

        assign ra      = i_raddr[slice_lo(k, AW) +: AW];
        assign ra_live = run && (ra != '0);

`ifdef REGFILE_BYPASS_EN
        logic wr_hit;
        logic iss_hit;

        assign wr_hit  = wr_en && (i_waddr == ra);
        assign iss_hit = iss_en && (i_issue_addr == ra);

        assign o_rdata[slice_lo(k, DATA_W) +: DATA_W] =
            !ra_live ? '0 : (wr_hit ? i_wdata : mem_q[ra]);
        assign o_busy[k] = ra_live && busy_q[ra] && !(wr_hit && !iss_hit);
`else
        assign o_rdata[slice_lo(k, DATA_W) +: DATA_W] = ra_live ? mem_q[ra] : '0;
        assign o_busy[k] = ra_live && busy_q[ra];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (default and NRD=4/DEPTH=16/DATA_W=64 instances)
module tb_regfile_mp;

    logic         clk;
    logic         reset;

    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [9:0]   raddr;
    logic [63:0]  rdata;
    logic         issue;
    logic [4:0]   issue_addr;
    logic [1:0]   busy;
    logic         ready;

    logic         we2;
    logic [3:0]   waddr2;
    logic [63:0]  wdata2;
    logic [15:0]  raddr2;
    logic [255:0] rdata2;
    logic         issue2;
    logic [3:0]   issue_addr2;
    logic [3:0]   busy2;
    logic         ready2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];

    regfile_mp dut (
        .clk          (clk),
        .reset        (reset),
        .i_we         (we),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .i_raddr      (raddr),
        .o_rdata      (rdata),
        .i_issue      (issue),
        .i_issue_addr (issue_addr),
        .o_busy       (busy),
        .o_ready      (ready)
    );

    regfile_mp #(
        .DATA_W (64),
        .DEPTH  (16),
        .NRD    (4)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .i_we         (we2),
        .i_waddr      (waddr2),
        .i_wdata      (wdata2),
        .i_raddr      (raddr2),
        .o_rdata      (rdata2),
        .i_issue      (issue2),
        .i_issue_addr (issue_addr2),
        .o_busy       (busy2),
        .o_ready      (ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] obs(input int kind, input int port);
        case (kind)
            0:       return {32'h0, rdata[port*32 +: 32]};
            1:       return {63'h0, busy[port]};
            2:       return rdata2[port*64 +: 64];
            3:       return {63'h0, busy2[port]};
            4:       return {63'h0, ready};
            default: return '0;
        endcase
    endfunction

    task automatic test_reset();
        int   cnt;
        exp_t e;
        logic [63:0] got;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        raddr = {5'd3, 5'd17};
        exp_q.push_back('{"rst_ready", 4, 0, 64'h0});
        exp_q.push_back('{"rst_busy0", 1, 0, 64'h0});
        exp_q.push_back('{"rst_rdata0", 0, 0, 64'h0});
        exp_q.push_back('{"rst_rdata1", 0, 1, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        cnt = 0;
        while (ready !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 32) begin
            errors++;
            $display("FAIL clear_latency: got %0d expected %0d", cnt, 32);
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            raddr = {a[4:0], a[4:0]};
            exp_q.push_back('{"clear_rd_p0", 0, 0, 64'h0});
            exp_q.push_back('{"clear_rd_p1", 0, 1, 64'h0});
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = obs(e.kind, e.port);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s r%0d: got %h expected %h", e.name, a, got, e.val);
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_ready: got %b expected 0", ready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 32) begin
            errors++;
            $display("FAIL restart_latency: got %0d expected %0d", cnt, 32);
        end
    endtask

    task automatic test_write();
        exp_t e;
        logic [63:0] got;
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        raddr = {5'd5, 5'd5};
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back('{"wr_r5_p0", 0, 0, 64'hDEADBEEF});
        exp_q.push_back('{"wr_r5_p1", 0, 1, 64'hDEADBEEF});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'h00001234;
        raddr = {5'd0, 5'd0};
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back('{"wr_r0_p0", 0, 0, 64'h0});
        exp_q.push_back('{"wr_r0_p1", 0, 1, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [63:0] got;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        @(negedge clk);
        wdata = 32'hA5A5A5A5;
        raddr = {5'd5, 5'd7};
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back('{"same_cycle_r7", 0, 0, 64'hA5A5A5A5});
`else
        exp_q.push_back('{"same_cycle_r7", 0, 0, 64'h11111111});
`endif
        exp_q.push_back('{"same_cycle_r5", 0, 1, 64'hDEADBEEF});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back('{"next_cycle_r7", 0, 0, 64'hA5A5A5A5});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_busy();
        exp_t e;
        logic [63:0] got;
        @(negedge clk);
        issue = 1'b1; issue_addr = 5'd9;
        raddr = {5'd9, 5'd10};
        @(negedge clk);
        issue = 1'b0;
        exp_q.push_back('{"busy_after_issue", 1, 1, 64'h1});
        exp_q.push_back('{"busy_other_reg", 1, 0, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        // r9 write retires while r10 is issued: both take effect
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        issue = 1'b1; issue_addr = 5'd10;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back('{"busy_wr_same_cycle", 1, 1, 64'h0});
`else
        exp_q.push_back('{"busy_wr_same_cycle", 1, 1, 64'h1});
`endif
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        we = 1'b0; issue = 1'b0;
        exp_q.push_back('{"busy_cleared_r9", 1, 1, 64'h0});
        exp_q.push_back('{"busy_set_r10", 1, 0, 64'h1});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h9A;
        issue = 1'b1; issue_addr = 5'd9;
        @(negedge clk);
        we = 1'b1; waddr = 5'd10; wdata = 32'hA0;
        issue = 1'b0;
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back('{"busy_issue_wins", 1, 1, 64'h1});
        exp_q.push_back('{"busy_cleared_r10", 1, 0, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_r0_and_clear();
        int   cnt;
        exp_t e;
        logic [63:0] got;
        @(negedge clk);
        issue = 1'b1; issue_addr = 5'd0;
        raddr = {5'd9, 5'd0};
        @(negedge clk);
        issue = 1'b0;
        exp_q.push_back('{"busy_r0", 1, 0, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; waddr = 5'd12; wdata = 32'hFFFFFFFF;
            issue = 1'b1; issue_addr = 5'd12;
            @(negedge clk);
        end
        we = 1'b0; issue = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        raddr = {5'd9, 5'd12};
        exp_q.push_back('{"clear_ready", 4, 0, 64'h1});
        exp_q.push_back('{"clear_ignored_wr", 0, 0, 64'h0});
        exp_q.push_back('{"clear_ignored_issue", 1, 0, 64'h0});
        exp_q.push_back('{"clear_busy_reset", 1, 1, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_wide();
        int   cnt;
        exp_t e;
        logic [63:0] got;
        logic [63:0] v;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (ready2 !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL wide_clear_latency: got %0d expected %0d", cnt, 16);
        end
        for (int r = 1; r <= 4; r++) begin
            v = {32'hC0DE0000 + 32'(r), 32'h5A5A0000 ^ 32'(r * 3)};
            we2 = 1'b1; waddr2 = r[3:0]; wdata2 = v;
            exp_q.push_back('{"wide_rd", 2, r - 1, v});
            @(negedge clk);
        end
        we2 = 1'b0;
        issue2 = 1'b1; issue_addr2 = 4'd3;
        @(negedge clk);
        issue2 = 1'b0;
        raddr2 = {4'd4, 4'd3, 4'd2, 4'd1};
        exp_q.push_back('{"wide_busy_r3", 3, 2, 64'h1});
        exp_q.push_back('{"wide_busy_r4", 3, 3, 64'h0});
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = obs(e.kind, e.port);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, got, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        issue = 1'b0; issue_addr = '0;
        we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
        issue2 = 1'b0; issue_addr2 = '0;
        test_reset();
        test_write();
        test_bypass();
        test_busy();
        test_r0_and_clear();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
